riscv_pipe_skid_stage: RTL
==========================

// Module: riscv_pipe_skid_stage
// PURPOSE
// - Parametrised elastic pipeline register for the RISC-V core; replaces fixed stall/flush stage regs (ID/EX, EX/MEM, MEM/WB).
// - Carries a control bundle and a data bundle under a valid/ready handshake.
// - 2-entry skid buffer: full throughput with a registered o_ready.
// - Flush zeroes control, keeps data; reports the flush one cycle later.
// PARAMETERS
// - CTRL_WIDTH      16  control bundle bits (width/jump/rd_write/read/write/wb_src/valid_instr/...); zeroed on flush
// - DATA_WIDTH      64  data bundle bits (pc, alu data, rs2 data, reg addrs packed by instantiator); not zeroed on flush
// - PERF_CNT_WIDTH  32  perf counter width (used only with RISCV_PIPE_STAGE_PERF_EN)
// PORTS
// - clk          in   1               clock, rising edge
// - nreset       in   1               asynchronous active-low reset
// - enable       in   1               stage enable; low freezes all state
// - i_flush      in   1               synchronous flush, highest priority
// - i_valid      in   1               upstream valid
// - o_ready      out  1               upstream ready = !skid_valid & enable
// - i_ctrl       in   CTRL_WIDTH      upstream control bundle
// - i_data       in   DATA_WIDTH      upstream data bundle
// - o_valid      out  1               downstream valid = main_valid & enable
// - i_ready      in   1               downstream ready
// - o_ctrl       out  CTRL_WIDTH      main-entry control
// - o_data       out  DATA_WIDTH      main-entry data
// - o_flushed    out  1               one-cycle pulse, cycle after i_flush is sampled
// - o_stall_cnt  out  PERF_CNT_WIDTH  cycles with o_valid & !i_ready
// - o_flush_cnt  out  PERF_CNT_WIDTH  number of sampled flushes
// BEHAVIOUR
// - Reset: state EMPTY; main/skid entries invalid; o_ctrl, o_data, o_flushed and both counters = 0; o_valid = 0; o_ready = 0 while nreset low.
// - Handshakes (both require enable):
//   - in_fire  = i_valid & o_ready
//   - out_fire = o_valid & i_ready
// - Latency: 1 cycle, input to o_valid. Throughput: 1 beat/cycle. Order preserved.
// - Upstream must hold i_valid/i_ctrl/i_data until in_fire; o_valid/o_ctrl/o_data stay stable until out_fire.
// - FSM states: EMPTY, BUSY (main valid), FULL (main + skid valid).
//   - EMPTY: in_fire -> BUSY, main <= in.
//   - BUSY: in_fire & !out_fire -> FULL, skid <= in.
//   - BUSY: !in_fire & out_fire -> EMPTY.
//   - BUSY: in_fire & out_fire -> BUSY, main <= in.
//   - FULL: out_fire -> BUSY, main <= skid. No in_fire is possible (o_ready = 0).
// - enable low: no fires, no state change. o_valid and o_ready forced 0; o_ctrl/o_data held. Counters hold.
// - i_flush (acts even when enable = 0):
//   - next state EMPTY; both entries invalid; main and skid ctrl <= 0; data registers unchanged.
//   - A same-cycle in_fire is discarded; out_fire in that cycle completes.
//   - o_flushed = 1 next cycle, otherwise 0.
// - Back-to-back flushes: o_flushed stays high for each flushed cycle + 1.
// - Async reset mid-transfer drops all entries with no handshake completion.
// CONFIGURATION
// - Macro RISCV_PIPE_STAGE_PERF_EN defined:
//   - o_stall_cnt increments each cycle with o_valid & !i_ready.
//   - o_flush_cnt increments each cycle i_flush is high.
//   - Both saturate at all-ones. Cleared only by reset.
// - Macro not defined: no counter flops; o_stall_cnt and o_flush_cnt tied to 0. Ports always present.
// STRUCTURE
// - riscv_pkg gets:
//   - typedef enum logic [1:0] {STG_EMPTY, STG_BUSY, STG_FULL} pipe_stage_state_e
//   - localparam PIPE_CTRL_RST = '0
// - Sub-module riscv_pipe_stage_entry: one valid + ctrl + data slot with load/clear; instantiated twice (main, skid).
// TESTING
// - Reset: nreset=0 mid-burst -> all outputs 0, state EMPTY; first beat after release appears 1 cycle after in_fire.
// - Streaming: i_ready=1, 8 beats data=0x10..0x17 back-to-back -> o_data 0x10..0x17 on consecutive cycles, o_ready stays 1.
// - Skid: i_ready=0 after beat 0xA0 accepted, send 0xA1 -> o_ready=0 next cycle; i_ready=1 -> 0xA0 then 0xA1, no loss/duplicate.
// - Flush in FULL with ctrl=0xFFFF -> next cycle o_valid=0, o_ctrl=0, o_data unchanged, o_flushed=1 for exactly 1 cycle.
// - Flush + in_fire same cycle: data 0x55 -> 0x55 never appears on the output; state EMPTY.
// - PERF_EN, PERF_CNT_WIDTH=4: hold i_ready=0 for 20 cycles with valid data -> o_stall_cnt=15 (saturated); 3 flushes -> o_flush_cnt=3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V core pipeline: skid-stage FSM states and the value
// control bundles are cleared to.
package riscv_pkg;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_BUSY  = 2'd1,
    STG_FULL  = 2'd2
  } pipe_stage_state_e;

  // Replicated across the control bundle width to form the reset/flush value.
  localparam logic PIPE_CTRL_RST = 1'b0;

endpackage

// File: rtl/riscv_pipe_stage_entry.sv
// One pipeline slot: valid + control + data. clear zeroes control but keeps data,
// drop only invalidates, so the slot's last contents stay visible downstream.
module riscv_pipe_stage_entry
  import riscv_pkg::*;
#(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  drop,
  input  logic [CTRL_WIDTH-1:0] ld_ctrl,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_WIDTH{PIPE_CTRL_RST}};
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_WIDTH{PIPE_CTRL_RST}};
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer and a registered o_ready.
// Optional perf counters are built only when RISCV_PIPE_STAGE_PERF_EN is defined.
module riscv_pipe_skid_stage
  import riscv_pkg::*;
#(
  parameter int CTRL_WIDTH     = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic                      i_flush,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [CTRL_WIDTH-1:0]     i_ctrl,
  input  logic [DATA_WIDTH-1:0]     i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [CTRL_WIDTH-1:0]     o_ctrl,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_flushed,
  output logic [PERF_CNT_WIDTH-1:0] o_stall_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_flush_cnt
);

  pipe_stage_state_e state, state_nxt;

  logic                  main_valid, skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  main_load, main_from_skid, main_drop;
  logic                  skid_load, skid_drop;
  logic                  in_fire, out_fire;

  // nreset gating keeps upstream stalled while the stage is held in reset.
  assign o_ready  = !skid_valid && enable && nreset;
  assign o_valid  = main_valid && enable;
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= STG_EMPTY;
      o_flushed <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_flushed <= i_flush;
    end
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (i_flush) begin
      state_nxt = STG_EMPTY;
    end else begin
      unique case (state)
        STG_EMPTY: begin
          if (in_fire) begin
            state_nxt = STG_BUSY;
            main_load = 1'b1;
          end
        end
        STG_BUSY: begin
          if (in_fire && !out_fire) begin
            state_nxt = STG_FULL;
            skid_load = 1'b1;
          end else if (!in_fire && out_fire) begin
            state_nxt = STG_EMPTY;
            main_drop = 1'b1;
          end else if (in_fire && out_fire) begin
            main_load = 1'b1;
          end
        end
        STG_FULL: begin
          if (out_fire) begin
            state_nxt      = STG_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
          end
        end
        default: state_nxt = STG_EMPTY;
      endcase
    end
  end

  riscv_pipe_stage_entry #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_main (
    .clk    (clk),
    .nreset (nreset),
    .clear  (i_flush),
    .load   (main_load),
    .drop   (main_drop),
    .ld_ctrl(main_from_skid ? skid_ctrl : i_ctrl),
    .ld_data(main_from_skid ? skid_data : i_data),
    .valid  (main_valid),
    .ctrl   (o_ctrl),
    .data   (o_data)
  );

  riscv_pipe_stage_entry #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .nreset (nreset),
    .clear  (i_flush),
    .load   (skid_load),
    .drop   (skid_drop),
    .ld_ctrl(i_ctrl),
    .ld_data(i_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

`ifdef RISCV_PIPE_STAGE_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cnt, flush_cnt;

  // Both counters saturate and freeze while the stage is disabled.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_CNT_WIDTH'(1);
      if (i_flush && enable && (flush_cnt != '1))
        flush_cnt <= flush_cnt + PERF_CNT_WIDTH'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
